// File: rtl/red_pkg.sv
// red_pkg: shared state encoding and sizing constants for the RED sequencer
package red_pkg;
  typedef enum logic [1:0] {RED_IDLE, RED_L1, RED_L2, RED_L3} red_state_t;
  localparam int RED_RES_W = 7;
  localparam int RED_NIBBLES = 8;
endpackage

// File: rtl/red_seq_ctrl_if.sv
// red_seq_ctrl_if: request/operand/result bundle between decode/hazard logic and the sequencer
interface red_seq_ctrl_if;
  logic start;
  logic stall;
  logic [15:0] A;
  logic [15:0] B;
  logic busy;
  logic done;
  logic [15:0] S;
  modport master (output start, stall, A, B, input busy, done, S);
  modport slave (input start, stall, A, B, output busy, done, S);
endinterface

// File: rtl/red_pair_adder.sv
// red_pair_adder: 8-bit adder built from two chained 4-bit carry-lookahead blocks
module red_pair_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] s
);
  logic [2:0] carry;
  assign carry[0] = 1'b0;
  assign s[8] = carry[2];
  for (genvar i = 0; i < 2; i++) begin : cla
    logic [3:0] g, p, c;
    assign g = a[4*i +: 4] & b[4*i +: 4];
    assign p = a[4*i +: 4] ^ b[4*i +: 4];
    assign c[0] = carry[i];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign carry[i+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                        | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign s[4*i +: 4] = p ^ c;
  end
endmodule

// File: rtl/red_seq_ctrl.sv
// red_seq_ctrl: nibble-sum reduction of A and B over 7 steps on one shared pair adder
module red_seq_ctrl
  import red_pkg::*;
(
  input logic clk,
  input logic rst,
  red_seq_ctrl_if.slave bus
);
  red_state_t state;
  logic [1:0] step;
  logic [15:0] op_a, op_b;
  logic [4:0] p [4];
  logic [5:0] q [2];
  logic [7:0] add_a, add_b;
  logic [8:0] sum;
  logic unused_carry;
  // Adder operands: nibble pairs in L1 (nibble 0 is the top nibble), p pairs in L2, q pair in L3
  assign add_a = state == RED_L1 ? {4'b0, op_a[{~step, 2'b00} +: 4]} :
                 state == RED_L2 ? {3'b0, p[{step[0], 1'b0}]} :
                 state == RED_L3 ? {2'b0, q[0]} : 8'h00;
  assign add_b = state == RED_L1 ? {4'b0, op_b[{~step, 2'b00} +: 4]} :
                 state == RED_L2 ? {3'b0, p[{step[0], 1'b1}]} :
                 state == RED_L3 ? {2'b0, q[1]} : 8'h00;
  assign unused_carry = ^sum[8:7];
  red_pair_adder u_add (.a(add_a), .b(add_b), .s(sum));
  // Sequencer: everything freezes under stall, so a pending done pulse is stretched rather than lost
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RED_IDLE;
      step <= 2'd0;
      op_a <= '0;
      op_b <= '0;
      p <= '{default: '0};
      q <= '{default: '0};
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.S <= '0;
    end else if (!bus.stall) begin
      bus.done <= 1'b0;
      case (state)
        RED_IDLE: if (bus.start) begin
          op_a <= bus.A;
          op_b <= bus.B;
          step <= 2'd0;
          bus.busy <= 1'b1;
          state <= RED_L1;
        end
        RED_L1: begin
          p[step] <= sum[4:0];
          step <= step + 2'd1;
          state <= step == 2'd3 ? RED_L2 : RED_L1;
        end
        RED_L2: begin
          q[step[0]] <= sum[5:0];
          step <= step[0] ? 2'd0 : 2'd1;
          state <= step[0] ? RED_L3 : RED_L2;
        end
        RED_L3: begin
          bus.S <= {{(16-RED_RES_W){1'b0}}, sum[RED_RES_W-1:0]};
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= RED_IDLE;
        end
        default: state <= RED_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_red_seq_ctrl.sv
// tb_red_seq_ctrl: directed and random checks of red_seq_ctrl against a nibble-sum model
module tb_red_seq_ctrl;
  import red_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [15:0] prev_s = 16'h0000;
  red_seq_ctrl_if bus ();
  red_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int s = 0;
    logic [31:0] ab = {a, b};
    for (int i = 0; i < RED_NIBBLES; i++) s += int'(ab[4*i +: 4]);
    return 16'(s);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int n, input int first);
    n = first;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
  endtask
  task automatic op(input logic [15:0] a, input logic [15:0] b, input string tag);
    int n;
    logic [15:0] e;
    e = model(a, b);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
    chk({tag, "_busy"}, {15'b0, bus.busy}, 16'h0001);
    chk({tag, "_hold"}, bus.S, prev_s);
    wait_done(n, 1);
    chk({tag, "_lat"}, 16'(n), 16'd8);
    chk({tag, "_S"}, bus.S, e);
    chk({tag, "_idle"}, {15'b0, bus.busy}, 16'h0000);
    prev_s = e;
  endtask
  initial begin
    int n;
    logic [15:0] e;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.A = 16'h0;
    bus.B = 16'h0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {15'b0, bus.busy}, 16'h0000);
    chk("rst_done", {15'b0, bus.done}, 16'h0000);
    chk("rst_S", bus.S, 16'h0000);
    op(16'hFFFF, 16'hFFFF, "t1");
    chk("t1_val", bus.S, 16'h0078);
    tick();
    chk("t1_pulse", {15'b0, bus.done}, 16'h0000);
    op(16'h1234, 16'h5678, "t2a");
    chk("t2a_val", bus.S, 16'h0024);
    tick();
    op(16'h0000, 16'h0000, "t2b");
    op(16'h000F, 16'h0001, "t3");
    chk("t3_val", bus.S, 16'h0010);
    tick();
    e = model(16'hA5C3, 16'h0F0F);
    bus.A = 16'hA5C3;
    bus.B = 16'h0F0F;
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
      tick();
    end
    bus.start = 1'b0;
    wait_done(n, 7);
    chk("t4_lat", 16'(n), 16'd8);
    chk("t4_S", bus.S, e);
    prev_s = e;
    tick();
    bus.stall = 1'b1;
    bus.start = 1'b1;
    tick();
    tick();
    chk("t5_idle_stall", {15'b0, bus.busy}, 16'h0000);
    bus.stall = 1'b0;
    bus.start = 1'b0;
    e = model(16'h9876, 16'h4321);
    bus.A = 16'h9876;
    bus.B = 16'h4321;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_stall_busy", {15'b0, bus.busy}, 16'h0001);
    chk("t5_stall_S", bus.S, prev_s);
    bus.stall = 1'b0;
    wait_done(n, 8);
    chk("t5_lat", 16'(n), 16'd11);
    chk("t5_S", bus.S, e);
    prev_s = e;
    bus.stall = 1'b1;
    tick();
    tick();
    chk("t5_stretch", {15'b0, bus.done}, 16'h0001);
    chk("t5_stretch_S", bus.S, e);
    bus.stall = 1'b0;
    tick();
    chk("t5_drop", {15'b0, bus.done}, 16'h0000);
    bus.A = 16'h7777;
    bus.B = 16'h8888;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", {15'b0, bus.busy}, 16'h0000);
    chk("t6_done", {15'b0, bus.done}, 16'h0000);
    chk("t6_S", bus.S, 16'h0000);
    prev_s = 16'h0000;
    tick();
    chk("t6_stay", {15'b0, bus.busy}, 16'h0000);
    op(16'h0F1E, 16'h2D3C, "t6_fresh");
    for (int k = 0; k < 20; k++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int i = 0; i < gap; i++) tick();
      op(16'($urandom), 16'($urandom), $sformatf("rnd%0d", k));
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
